// File: rtl/comparador22_6bit_pkg.sv
// comparador22_pkg: shared widths, membership mask and mask sanity helper
package comparador22_pkg;

    localparam int CMP_W   = 6;
    localparam int DEC_W   = 3;
    localparam int MEMBERS = 22;

    // Bit v set for every multiple of 3 in 0..63; used only at elaboration and by verification
    localparam logic [63:0] S_MASK = 64'h9249_2492_4924_9249;

    function automatic int popcount_check(input logic [63:0] mask);
        int count;
        count = 0;
        for (int i = 0; i < 64; i++) count += int'(mask[i]);
        return count;
    endfunction

endpackage

// File: rtl/comparador22_6bit_if.sv
// comparador22_6bit_if: operand inputs and registered result bundle
interface comparador22_6bit_if;
    import comparador22_pkg::*;

    logic [CMP_W-1:0]      estimulo;
    logic [DEC_W-1:0]      estimulo_dec;
    logic                  match_compuertas;
    logic                  match_decodificador;
    logic [(1<<DEC_W)-1:0] dec_out;
    logic                  mismatch;

    modport master (
        output estimulo, estimulo_dec,
        input  match_compuertas, match_decodificador, dec_out, mismatch
    );

    modport slave (
        input  estimulo, estimulo_dec,
        output match_compuertas, match_decodificador, dec_out, mismatch
    );

endinterface

// File: rtl/comparador22_6bit_decodificador.sv
// decodificador_3a8: combinational 3-to-8 one-hot decoder
module decodificador_3a8
    import comparador22_pkg::*;
(
    input  logic [DEC_W-1:0]      sel,
    output logic [(1<<DEC_W)-1:0] one_hot
);

    assign one_hot = 8'b1 << sel;

endmodule

// File: rtl/comparador22_6bit.sv
// comparador22_6bit: registered multiple-of-3 membership check via two independent paths plus a 3-to-8 decode
module comparador22_6bit
    import comparador22_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    comparador22_6bit_if.slave  bus
);

    logic [CMP_W-1:0] e;
    logic [CMP_W-1:0] n;
    logic [7:0]       hi_oh;
    logic [7:0]       lo_oh;
    logic [7:0]       dec_oh;
    logic [63:0]      pair_hit;
    logic             gate_match;
    logic             dec_match;

    // The pair network below is derived from S_MASK, so a corrupted mask must stop elaboration
    if (popcount_check(S_MASK) != MEMBERS) begin : g_bad_mask
        $error("S_MASK must contain exactly 22 members");
    end

    assign e = bus.estimulo;
    assign n = ~bus.estimulo;

    // Gate path: one minterm per member, no arithmetic and no table
    assign gate_match =
          (n[5] & n[4] & n[3] & n[2] & n[1] & n[0])   //  0
        | (n[5] & n[4] & n[3] & n[2] & e[1] & e[0])   //  3
        | (n[5] & n[4] & n[3] & e[2] & e[1] & n[0])   //  6
        | (n[5] & n[4] & e[3] & n[2] & n[1] & e[0])   //  9
        | (n[5] & n[4] & e[3] & e[2] & n[1] & n[0])   // 12
        | (n[5] & n[4] & e[3] & e[2] & e[1] & e[0])   // 15
        | (n[5] & e[4] & n[3] & n[2] & e[1] & n[0])   // 18
        | (n[5] & e[4] & n[3] & e[2] & n[1] & e[0])   // 21
        | (n[5] & e[4] & e[3] & n[2] & n[1] & n[0])   // 24
        | (n[5] & e[4] & e[3] & n[2] & e[1] & e[0])   // 27
        | (n[5] & e[4] & e[3] & e[2] & e[1] & n[0])   // 30
        | (e[5] & n[4] & n[3] & n[2] & n[1] & e[0])   // 33
        | (e[5] & n[4] & n[3] & e[2] & n[1] & n[0])   // 36
        | (e[5] & n[4] & n[3] & e[2] & e[1] & e[0])   // 39
        | (e[5] & n[4] & e[3] & n[2] & e[1] & n[0])   // 42
        | (e[5] & n[4] & e[3] & e[2] & n[1] & e[0])   // 45
        | (e[5] & e[4] & n[3] & n[2] & n[1] & n[0])   // 48
        | (e[5] & e[4] & n[3] & n[2] & e[1] & e[0])   // 51
        | (e[5] & e[4] & n[3] & e[2] & e[1] & n[0])   // 54
        | (e[5] & e[4] & e[3] & n[2] & n[1] & e[0])   // 57
        | (e[5] & e[4] & e[3] & e[2] & n[1] & n[0])   // 60
        | (e[5] & e[4] & e[3] & e[2] & e[1] & e[0]);  // 63

    decodificador_3a8 u_dec_hi (.sel(bus.estimulo[5:3]), .one_hot(hi_oh));
    decodificador_3a8 u_dec_lo (.sel(bus.estimulo[2:0]), .one_hot(lo_oh));
    decodificador_3a8 u_dec_st (.sel(bus.estimulo_dec),  .one_hot(dec_oh));

    // Decoder path: only the 22 (hi, lo) pairs whose value 8h+l is a member get an AND term
    for (genvar h = 0; h < 8; h++) begin : g_h
        for (genvar l = 0; l < 8; l++) begin : g_l
            if (S_MASK[8*h+l]) begin : g_on
                assign pair_hit[8*h+l] = hi_oh[h] & lo_oh[l];
            end else begin : g_off
                assign pair_hit[8*h+l] = 1'b0;
            end
        end
    end

    assign dec_match = |pair_hit;

    // Output registers; reset clears everything asynchronously and drops the in-flight result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.match_compuertas    <= 1'b0;
            bus.match_decodificador <= 1'b0;
            bus.dec_out             <= 8'h00;
            bus.mismatch            <= 1'b0;
        end else begin
            bus.match_compuertas    <= gate_match;
            bus.match_decodificador <= dec_match;
            bus.dec_out             <= dec_oh;
            bus.mismatch            <= gate_match ^ dec_match;
        end
    end

endmodule

// File: tb/tb_comparador22_6bit.sv
// tb_comparador22_6bit: random and directed checks against a modulo-3 reference model
module tb_comparador22_6bit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   hits;

    comparador22_6bit_if bus ();

    comparador22_6bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_match(input int v);
        return (v % 3) == 0;
    endfunction

    function automatic logic [7:0] ref_dec(input int d);
        logic [7:0] r;
        r = '0;
        r[d] = 1'b1;
        return r;
    endfunction

    task automatic expect_zero(input string tag);
        chk({tag, "_mc"},  8'(bus.match_compuertas),    8'h0);
        chk({tag, "_md"},  8'(bus.match_decodificador), 8'h0);
        chk({tag, "_dec"}, bus.dec_out,                 8'h00);
        chk({tag, "_mm"},  8'(bus.mismatch),            8'h0);
    endtask

    task automatic step(input string tag, input int v, input int d);
        bus.estimulo     = 6'(v);
        bus.estimulo_dec = 3'(d);
        @(posedge clk);
        #1;
        chk({tag, "_mc"},  8'(bus.match_compuertas),    8'(ref_match(v)));
        chk({tag, "_md"},  8'(bus.match_decodificador), 8'(ref_match(v)));
        chk({tag, "_dec"}, bus.dec_out,                 ref_dec(d));
        chk({tag, "_mm"},  8'(bus.mismatch),            8'h0);
    endtask

    initial begin
        bus.estimulo     = 6'd15;
        bus.estimulo_dec = 3'd5;
        #2;
        expect_zero("rst_initial");
        @(posedge clk);
        #1;
        expect_zero("rst_held_edge");
        #3 rst_n = 1'b1;
        #1;
        expect_zero("rst_release");

        hits = 0;
        for (int v = 0; v < 64; v++) begin
            step("sweep", v, v % 8);
            hits += int'(bus.match_compuertas & bus.match_decodificador);
        end
        chk("sweep_hits", 8'(hits), 8'd22);

        for (int d = 0; d < 8; d++) step("decsweep", 1, d);

        step("bnd62", 62, 0);
        step("bnd63", 63, 7);
        chk("bnd63_dec80", bus.dec_out, 8'h80);
        step("bnd0", 0, 3);

        for (int v = 30; v <= 33; v++) step("pre_rst", v, 2);
        rst_n = 1'b0;
        #1;
        expect_zero("rst_async");
        bus.estimulo     = 6'd36;
        bus.estimulo_dec = 3'd4;
        #2 rst_n = 1'b1;
        #1;
        expect_zero("rst_wait_edge");
        @(posedge clk);
        #1;
        chk("post_rst_36_mc", 8'(bus.match_compuertas),    8'h1);
        chk("post_rst_36_md", 8'(bus.match_decodificador), 8'h1);
        chk("post_rst_dec",   bus.dec_out,                 8'h10);

        for (int i = 0; i < 1000; i++) step("rand", int'($urandom_range(63)), int'($urandom_range(7)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
